spine_port_arbiter: RTL and testbench

//  Per-output-port wormhole arbiter for the 11-port spine router: shares one output

---
 rtl/spine_pkg.sv | 24 ++
 rtl/spine_port_arbiter_if.sv | 29 ++
 rtl/rr_picker.sv | 32 +++
 rtl/spine_port_arbiter.sv | 127 ++++++++++++
 tb/tb_spine_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spine_pkg.sv
// Shared constants for the 11-port spine router: port map, arbiter state encoding and
// flit field layout.
package spine_pkg;

  localparam int unsigned NUM_PORTS = 11;

  // Ports 0..7 face leaf nodes, ports 8..10 face the group links.
  localparam int unsigned LEAF_PORT_FIRST  = 0;
  localparam int unsigned LEAF_PORT_LAST   = 7;
  localparam int unsigned GROUP_PORT_FIRST = 8;
  localparam int unsigned GROUP_PORT_LAST  = 10;

  // Output-port arbiter state encoding.
  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_LOCK = 1'b1;

  // Flit layout: destination port in the low nibble, payload above it.
  localparam int unsigned FLIT_W           = 16;
  localparam int unsigned FLIT_DEST_LSB    = 0;
  localparam int unsigned FLIT_DEST_W      = 4;
  localparam int unsigned FLIT_PAYLOAD_LSB = 4;
  localparam int unsigned FLIT_PAYLOAD_W   = 12;

endpackage

// File: rtl/spine_port_arbiter_if.sv
// Requester/output bundle of one output-port arbiter. The master side feeds head flits
// and the output-FIFO full flag; the slave side is the arbiter itself.
interface spine_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 11,
  parameter int unsigned DWIDTH  = 16
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]        pop;
  logic [NUM_REQ-1:0]        grant;
  logic                      out_full;
  logic [DWIDTH-1:0]         out_data;
  logic                      out_valid;
  logic                      busy;
  logic                      err_overlen;

  modport master (
    output req, req_last, req_data, out_full,
    input  pop, grant, out_data, out_valid, busy, err_overlen
  );

  modport slave (
    input  req, req_last, req_data, out_full,
    output pop, grant, out_data, out_valid, busy, err_overlen
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 11
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         winner,
  output logic                       any
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan from rr_ptr upward, wrapping at NUM_REQ-1, and keep the first hit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 0; off < int'(NUM_REQ); off++) begin
      idx = PTR_W'((int'(rr_ptr) + off) % int'(NUM_REQ));
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spine_port_arbiter.sv
// Wormhole output-port arbiter: round-robin grant, held for a whole packet (tail flit or
// MAX_PKT_LEN cap), muxing the owner's head flits into the output FIFO write port.
module spine_port_arbiter
  import spine_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_PORTS,
  parameter int unsigned DWIDTH      = FLIT_W,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input logic                clk,
  input logic                reset,
  spine_port_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(NUM_REQ - 1);

  logic               state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   flit_cnt_q, flit_cnt_d;
  logic [DWIDTH-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] pick;
  logic               pick_any;
  logic [NUM_REQ-1:0] pop;
  logic               pop_any;
  logic               pop_last;
  logic               at_cap;
  logic [PTR_W-1:0]   owner_idx;
  logic [DWIDTH-1:0]  pop_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .winner (pick),
    .any    (pick_any)
  );

  // Only the lock owner is ever popped, and only when the output FIFO has room.
  assign pop      = (state_q == ARB_LOCK && !bus.out_full) ? (grant_q & bus.req) : '0;
  assign pop_any  = |pop;
  assign pop_last = |(pop & bus.req_last);
  assign at_cap   = (flit_cnt_q == CNT_CAP);

  // Owner index for the round-robin advance, and the popped flit (pop is one-hot/zero).
  always_comb begin
    owner_idx = '0;
    pop_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
      if (pop[i]) pop_data = pop_data | bus.req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Grant/lock FSM with flit counting and overlength detection.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    flit_cnt_d = flit_cnt_q;
    err_d      = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d    = ARB_LOCK;
          grant_d    = pick;
          flit_cnt_d = '0;
        end
      end
      default: begin
        if (pop_any) begin
          flit_cnt_d = flit_cnt_q + 1'b1;
          if (pop_last || at_cap) begin
            state_d    = ARB_IDLE;
            grant_d    = '0;
            flit_cnt_d = '0;
            rr_ptr_d   = (owner_idx == PTR_TOP) ? '0 : owner_idx + 1'b1;
            // A tail on the capping flit is a legal max-length packet.
            if (!pop_last) err_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Output write port: strobe follows pop by one cycle, data holds when idle.
  always_comb begin
    out_valid_d = pop_any;
    out_data_d  = pop_any ? pop_data : out_data_q;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      flit_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      flit_cnt_q  <= flit_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.pop         = pop;
  assign bus.grant       = grant_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (state_q == ARB_LOCK);
  assign bus.err_overlen = err_q;

endmodule

// File: tb/tb_spine_port_arbiter.sv
// Bench for spine_port_arbiter: a per-cycle vector table for the basic packet and
// round-robin advance, hand sequences for the multi-cycle corners, and a scoreboard of
// expected output flits checked whenever out_valid is seen.
module tb_spine_port_arbiter;

  localparam int unsigned NR  = 11;
  localparam int unsigned DW  = 16;
  localparam int unsigned MPL = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spine_port_arbiter_if #(.NUM_REQ(NR), .DWIDTH(DW)) bus ();

  spine_port_arbiter #(
    .NUM_REQ     (NR),
    .DWIDTH      (DW),
    .MAX_PKT_LEN (MPL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] last;
    logic [DW-1:0] data;
    logic          full;
    logic [NR-1:0] exp_grant;
    logic [NR-1:0] exp_pop;
    logic          exp_valid;
    logic          exp_busy;
  } vec_t;

  vec_t          tbl [9];
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Negedge sample: pop legality and the output-flit scoreboard.
  task automatic sample();
    logic [DW-1:0] e;
    @(negedge clk);
    check("pop_onehot0", 32'($onehot0(bus.pop)), 32'd1);
    check("pop_non_owner", 32'(bus.pop & ~bus.grant), 32'd0);
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got flit %0h want none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 32'(bus.out_data), 32'(e));
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.req      = '1;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.out_full = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_pop", 32'(bus.pop), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err_overlen), 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bus.req = '0;
  endtask

  task automatic drain();
    bus.req      = '0;
    bus.req_last = '0;
    bus.out_full = 1'b0;
    repeat (3) begin
      sample();
      next_cycle();
    end
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [NR-1:0] eg;
    logic          full;
    logic          prev_pop;
    int            f;

    //          req      last     data      full  grant    pop      vld   busy
    tbl[0] = '{11'h001, 11'h000, 16'h1A00, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0};
    tbl[1] = '{11'h001, 11'h000, 16'h1A00, 1'b0, 11'h001, 11'h001, 1'b0, 1'b1};
    tbl[2] = '{11'h001, 11'h000, 16'h1A01, 1'b0, 11'h001, 11'h001, 1'b1, 1'b1};
    tbl[3] = '{11'h001, 11'h001, 16'h1A02, 1'b0, 11'h001, 11'h001, 1'b1, 1'b1};
    tbl[4] = '{11'h000, 11'h000, 16'h1A03, 1'b0, 11'h000, 11'h000, 1'b1, 1'b0};
    // rr_ptr is now 1: with 0 and 1 both requesting, 1 wins.
    tbl[5] = '{11'h003, 11'h7FF, 16'h1A03, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0};
    tbl[6] = '{11'h003, 11'h7FF, 16'h1A03, 1'b0, 11'h002, 11'h002, 1'b0, 1'b1};
    tbl[7] = '{11'h000, 11'h000, 16'h1A04, 1'b0, 11'h000, 11'h000, 1'b1, 1'b0};
    tbl[8] = '{11'h000, 11'h000, 16'h1A04, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0};

    // Single 3-flit packet from requester 0, then round-robin pointer advance.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.req      = tbl[i].req;
      bus.req_last = tbl[i].last;
      bus.req_data = {NR{tbl[i].data}};
      bus.out_full = tbl[i].full;
      if (tbl[i].exp_pop != '0) exp_q.push_back(tbl[i].data);
      sample();
      check($sformatf("t1_grant[%0d]", i), 32'(bus.grant), 32'(tbl[i].exp_grant));
      check($sformatf("t1_pop[%0d]", i), 32'(bus.pop), 32'(tbl[i].exp_pop));
      check($sformatf("t1_valid[%0d]", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
      check($sformatf("t1_busy[%0d]", i), 32'(bus.busy), 32'(tbl[i].exp_busy));
      next_cycle();
    end
    drain();

    // All requesters, 1-flit packets: grants 0..10 then 0, two cycles each.
    do_reset();
    bus.req      = '1;
    bus.req_last = '1;
    for (int i = 0; i < int'(NR); i++) bus.req_data[i*DW +: DW] = 16'h2000 + 16'(i);
    for (int c = 0; c < 24; c++) begin
      eg = (c % 2 == 1) ? (NR'(1) << (((c - 1) / 2) % NR)) : '0;
      if (eg != '0) exp_q.push_back(16'h2000 + 16'(((c - 1) / 2) % NR));
      sample();
      check($sformatf("t2_grant[%0d]", c), 32'(bus.grant), 32'(eg));
      check($sformatf("t2_pop[%0d]", c), 32'(bus.pop), 32'(eg));
      next_cycle();
    end
    drain();

    // Owner 4 drops req mid-packet while 2 waits: lock held, nobody popped.
    do_reset();
    for (int i = 0; i < int'(NR); i++) bus.req_data[i*DW +: DW] = 16'h3000 + 16'(i);
    bus.req      = 11'h010;
    bus.req_last = '0;
    sample();
    next_cycle();
    exp_q.push_back(16'h3004);
    sample();
    check("t3_grant", 32'(bus.grant), 32'h010);
    check("t3_pop", 32'(bus.pop), 32'h010);
    next_cycle();
    bus.req = 11'h004;
    repeat (3) begin
      sample();
      check("t3_hold_grant", 32'(bus.grant), 32'h010);
      check("t3_hold_pop", 32'(bus.pop), 32'h000);
      check("t3_hold_busy", 32'(bus.busy), 32'd1);
      next_cycle();
    end
    bus.req      = 11'h014;
    bus.req_last = 11'h010;
    exp_q.push_back(16'h3004);
    sample();
    check("t3_tail_pop", 32'(bus.pop), 32'h010);
    next_cycle();
    bus.req      = 11'h004;
    bus.req_last = 11'h004;
    sample();
    check("t3_bubble", 32'(bus.grant), 32'h000);
    next_cycle();
    exp_q.push_back(16'h3002);
    sample();
    check("t3_next_grant", 32'(bus.grant), 32'h004);
    check("t3_next_pop", 32'(bus.pop), 32'h004);
    next_cycle();
    drain();

    // Output FIFO full for 5 cycles inside a 6-flit packet: stall, no flit lost.
    do_reset();
    bus.req  = 11'h001;
    f        = 0;
    prev_pop = 1'b0;
    bus.req_data[0 +: DW] = 16'h4000;
    sample();
    next_cycle();
    for (int c = 1; c < 20 && f < 6; c++) begin
      full                  = (c >= 3 && c < 8);
      bus.out_full          = full;
      bus.req_data[0 +: DW] = 16'h4000 + 16'(f);
      bus.req_last          = (f == 5) ? 11'h001 : 11'h000;
      if (!full) exp_q.push_back(16'h4000 + 16'(f));
      sample();
      check($sformatf("t4_pop[%0d]", c), 32'(bus.pop), full ? 32'h0 : 32'h1);
      check($sformatf("t4_valid[%0d]", c), 32'(bus.out_valid), 32'(prev_pop));
      check($sformatf("t4_grant[%0d]", c), 32'(bus.grant), 32'h001);
      if (bus.pop[0]) f++;
      prev_pop = !full;
      next_cycle();
    end
    check("t4_flits", 32'(f), 32'd6);
    drain();

    // 20 flits without a tail: forced release after 16 pops, sticky error.
    do_reset();
    bus.req      = 11'h001;
    bus.req_last = '0;
    sample();
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      bus.req_data[0 +: DW] = 16'h5000 + 16'(i);
      exp_q.push_back(16'h5000 + 16'(i));
      sample();
      check($sformatf("t5_pop[%0d]", i), 32'(bus.pop), 32'h001);
      check($sformatf("t5_err_pre[%0d]", i), 32'(bus.err_overlen), 32'd0);
      next_cycle();
    end
    bus.req_data[0 +: DW] = 16'h5010;
    sample();
    check("t5_release_grant", 32'(bus.grant), 32'h000);
    check("t5_release_pop", 32'(bus.pop), 32'h000);
    check("t5_release_busy", 32'(bus.busy), 32'd0);
    check("t5_err_set", 32'(bus.err_overlen), 32'd1);
    next_cycle();
    for (int i = 16; i < 20; i++) begin
      bus.req_data[0 +: DW] = 16'h5000 + 16'(i);
      bus.req_last          = (i == 19) ? 11'h001 : 11'h000;
      exp_q.push_back(16'h5000 + 16'(i));
      sample();
      check($sformatf("t5_tail_pop[%0d]", i), 32'(bus.pop), 32'h001);
      next_cycle();
    end
    drain();
    check("t5_err_sticky", 32'(bus.err_overlen), 32'd1);

    // Exactly MAX_PKT_LEN flits with the tail on the last one: no error.
    do_reset();
    bus.req      = 11'h001;
    bus.req_last = '0;
    sample();
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      bus.req_data[0 +: DW] = 16'h5800 + 16'(i);
      bus.req_last          = (i == 15) ? 11'h001 : 11'h000;
      exp_q.push_back(16'h5800 + 16'(i));
      sample();
      next_cycle();
    end
    bus.req = '0;
    sample();
    check("t5b_grant", 32'(bus.grant), 32'h000);
    check("t5b_err", 32'(bus.err_overlen), 32'd0);
    next_cycle();
    drain();

    // Asynchronous reset between edges while locked and writing.
    do_reset();
    bus.req               = 11'h001;
    bus.req_last          = '0;
    bus.req_data[0 +: DW] = 16'h6000;
    sample();
    next_cycle();
    exp_q.push_back(16'h6000);
    sample();
    check("t6_pop", 32'(bus.pop), 32'h001);
    next_cycle();
    check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    check("t6_pre_grant", 32'(bus.grant), 32'h001);
    #2;
    reset = 1'b1;
    #1;
    check("t6_grant", 32'(bus.grant), 32'h000);
    check("t6_pop_rst", 32'(bus.pop), 32'h000);
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
